alu_issue_sched: RTL and testbench
==================================

Name: alu_issue_sched

Overview:
- Sequential replacement for the DP-stage static functional-unit allocation.
- Shares two ALUs between the two dispatch slots using per-ALU busy counters and a round-robin pointer.
- Grants with a same-cycle valid/ready handshake, in program order.
- Issues registered start pulses to the ALUs one cycle after each grant.

Parameters:
- LAT_W, 3: width of the operation latency field and of each ALU busy counter (max latency 2^LAT_W-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous pipeline flush.
- dp_valid1  in  1  slot 1 (older instruction) requests an ALU.
- dp_lat1  in  LAT_W  slot 1 operation latency in cycles.
- dp_valid2  in  1  slot 2 (younger instruction) requests an ALU.
- dp_lat2  in  LAT_W  slot 2 operation latency in cycles.
- dp_ready1  out  1  slot 1 granted this cycle (combinational).
- dp_ready2  out  1  slot 2 granted this cycle (combinational).
- fu0_start  out  1  ALU0 start pulse (registered).
- fu0_src  out  1  source of the ALU0 op: 0 = slot 1, 1 = slot 2.
- fu0_lat  out  LAT_W  latency of the op issued to ALU0.
- fu1_start  out  1  ALU1 start pulse (registered).
- fu1_src  out  1  source of the ALU1 op.
- fu1_lat  out  LAT_W  latency of the op issued to ALU1.
- fu_busy  out  2  per-ALU busy flags: bit0 = ALU0, bit1 = ALU1.
- rr_ptr  out  1  preferred ALU for the next single grant.

Behaviour:
- Reset (async) values:
  - busy counters = 0, rr_ptr = 0, fu_busy = 2'b00.
  - fuN_start = 0, fuN_src = 0, fuN_lat = 0.
  - dp_ready1/2 forced 0 while rst is high.
- Effective latency: L = 0 is treated as L = 1.
- ALU n is free when its counter is 0. fu_busy[n] = (counter != 0).
- On grant to ALU n, the counter loads L-1 at the clock edge, so an L=1 op leaves the ALU free next cycle.
- Otherwise a nonzero counter decrements by 1 per cycle.
- A counter may reload in the same cycle it reaches 0 (back-to-back issue).
- Allocation each cycle, with F = set of free ALUs:
  - Both slots valid, both ALUs free: slot 1 -> ALU0, slot 2 -> ALU1. rr_ptr unchanged.
  - Both slots valid, exactly one ALU free: slot 1 gets it, dp_ready2 = 0. This keeps in-order issue.
  - One slot valid, both ALUs free: the slot goes to ALU rr_ptr.
  - One slot valid, one ALU free: the slot gets the free ALU.
  - No ALU free: dp_ready1 = dp_ready2 = 0.
  - Slot 2 may be granted only if slot 1 is granted this cycle or dp_valid1 = 0.
- rr_ptr update:
  - After any single grant, rr_ptr = the ALU not granted.
  - After a double grant or no grant, rr_ptr holds.
- Handshake:
  - dp_readyX is asserted only when dp_validX = 1; it never asserts for an invalid slot.
  - The requester holds valid and lat until ready.
- Issue:
  - In the cycle after a grant to ALU n: fuN_start = 1 for exactly one cycle, with fuN_src and fuN_lat = the granted slot's values.
  - fuN_src/fuN_lat hold their last value when start = 0.
- Flush (synchronous, highest priority after rst):
  - dp_ready1/2 = 0 in the flush cycle.
  - At the edge: all counters cleared, rr_ptr = 0, fuN_start = 0 next cycle.
  - Ops issued before the flush are squashed by the ALUs; this block only forgets their occupancy.
- Reset mid-operation: counters, pointer and start pulses clear immediately. No start pulse after reset deasserts without a new grant.
- Latency: grant cycle T -> fuN_start at T+1 -> fu_busy[n] = 1 from T+1 while L > 1.

Test Plan:
- Reset, then dp_valid1 = dp_valid2 = 1, lat 1/1:
  - dp_ready1 = dp_ready2 = 1 in cycle 0.
  - Next cycle fu0_start = 1 (src 0) and fu1_start = 1 (src 1); rr_ptr stays 0.
- Single-slot alternation: dp_valid1 only, lat 1, four consecutive cycles:
  - Issues to ALU0, ALU1, ALU0, ALU1.
  - rr_ptr toggles 1, 0, 1, 0.
- Busy blocking:
  - Issue lat 4 to ALU0 and lat 4 to ALU1.
  - Request both slots each cycle: no ready for 3 cycles after the grant.
  - Both granted on the 4th cycle after the grant.
- Partial availability:
  - ALU0 busy (lat 5 from a slot-1-only grant with rr_ptr = 0), ALU1 free.
  - Both slots valid: only dp_ready1 = 1, issued to ALU1; dp_ready2 = 0.
- Flush mid-op:
  - Grant lat 7 to ALU0, flush 2 cycles later.
  - fu_busy = 00 and rr_ptr = 0 next cycle.
  - A new request is granted immediately after.
- Async reset mid-op: assert rst between edges while fu1_start = 1. fu1_start, fu_busy and rr_ptr go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/alu_issue_sched_if.sv
// Dispatch-to-ALU scheduling bus: two dispatch request slots in, ALU start
// pulses and scheduler status out.
interface alu_issue_sched_if #(
  parameter int unsigned LAT_W = 3
);
  logic             flush;
  logic             dp_valid1;
  logic [LAT_W-1:0] dp_lat1;
  logic             dp_valid2;
  logic [LAT_W-1:0] dp_lat2;
  logic             dp_ready1;
  logic             dp_ready2;
  logic             fu0_start;
  logic             fu0_src;
  logic [LAT_W-1:0] fu0_lat;
  logic             fu1_start;
  logic             fu1_src;
  logic [LAT_W-1:0] fu1_lat;
  logic [1:0]       fu_busy;
  logic             rr_ptr;

  modport master (
    output flush, dp_valid1, dp_lat1, dp_valid2, dp_lat2,
    input  dp_ready1, dp_ready2, fu0_start, fu0_src, fu0_lat,
           fu1_start, fu1_src, fu1_lat, fu_busy, rr_ptr
  );

  modport slave (
    input  flush, dp_valid1, dp_lat1, dp_valid2, dp_lat2,
    output dp_ready1, dp_ready2, fu0_start, fu0_src, fu0_lat,
           fu1_start, fu1_src, fu1_lat, fu_busy, rr_ptr
  );
endinterface

// File: rtl/alu_issue_sched.sv
// Shares two ALUs between two in-order dispatch slots using per-ALU busy
// counters and a round-robin pointer; starts are issued one cycle after grant.
module alu_issue_sched #(
  parameter int unsigned LAT_W = 3
) (
  input logic               clk,
  input logic               rst,
  alu_issue_sched_if.slave  bus
);

  logic [1:0][LAT_W-1:0] cnt_q, cnt_d;
  logic [1:0][LAT_W-1:0] glat, lat_q;
  logic [1:0]            free, grant, gsrc;
  logic [1:0]            start_q, src_q, busy_q;
  logic                  rr_q, rr_d;
  logic                  ready1, ready2;
  logic                  tgt, one_src;
  logic [LAT_W-1:0]      one_lat;

  // Latency 0 behaves as latency 1, so both load a zero residual count.
  function automatic logic [LAT_W-1:0] load_val(input logic [LAT_W-1:0] lat);
    return (lat == '0) ? '0 : LAT_W'(lat - LAT_W'(1));
  endfunction

  // Allocation: slot 1 always has priority so issue stays in program order.
  always_comb begin
    free    = {cnt_q[1] == '0, cnt_q[0] == '0};
    ready1  = 1'b0;
    ready2  = 1'b0;
    grant   = 2'b00;
    gsrc    = 2'b00;
    glat    = '0;
    tgt     = 1'b0;
    one_src = ~bus.dp_valid1;
    one_lat = bus.dp_valid1 ? bus.dp_lat1 : bus.dp_lat2;
    if (!rst && !bus.flush) begin
      if (bus.dp_valid1 && bus.dp_valid2) begin
        if (free == 2'b11) begin
          ready1  = 1'b1;
          ready2  = 1'b1;
          grant   = 2'b11;
          gsrc    = 2'b10;
          glat[0] = bus.dp_lat1;
          glat[1] = bus.dp_lat2;
        end else if (free != 2'b00) begin
          tgt        = free[1];
          ready1     = 1'b1;
          grant[tgt] = 1'b1;
          glat[tgt]  = bus.dp_lat1;
        end
      end else if (bus.dp_valid1 || bus.dp_valid2) begin
        tgt = (free == 2'b11) ? rr_q : free[1];
        if (free != 2'b00) begin
          ready1     = bus.dp_valid1;
          ready2     = bus.dp_valid2;
          grant[tgt] = 1'b1;
          gsrc[tgt]  = one_src;
          glat[tgt]  = one_lat;
        end
      end
    end
  end

  // Next-state: counter reload/decrement, pointer moves away from a single grant.
  always_comb begin
    cnt_d = cnt_q;
    rr_d  = rr_q;
    for (int n = 0; n < 2; n++) begin
      if (grant[n]) begin
        cnt_d[n] = load_val(glat[n]);
      end else if (cnt_q[n] != '0) begin
        cnt_d[n] = LAT_W'(cnt_q[n] - LAT_W'(1));
      end
    end
    if (grant == 2'b01) begin
      rr_d = 1'b1;
    end else if (grant == 2'b10) begin
      rr_d = 1'b0;
    end
    if (bus.flush) begin
      cnt_d = '0;
      rr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      busy_q  <= 2'b00;
      start_q <= 2'b00;
      src_q   <= 2'b00;
      lat_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      busy_q  <= {cnt_d[1] != '0, cnt_d[0] != '0};
      start_q <= grant;
      for (int n = 0; n < 2; n++) begin
        if (grant[n]) begin
          src_q[n] <= gsrc[n];
          lat_q[n] <= glat[n];
        end
      end
    end
  end

  assign bus.dp_ready1 = ready1;
  assign bus.dp_ready2 = ready2;
  assign bus.fu0_start = start_q[0];
  assign bus.fu0_src   = src_q[0];
  assign bus.fu0_lat   = lat_q[0];
  assign bus.fu1_start = start_q[1];
  assign bus.fu1_src   = src_q[1];
  assign bus.fu1_lat   = lat_q[1];
  assign bus.fu_busy   = busy_q;
  assign bus.rr_ptr    = rr_q;

endmodule

// File: tb/tb_alu_issue_sched.sv
// Bench for alu_issue_sched: directed scenarios plus random traffic, all checked
// against a cycle-timestamp model of ALU occupancy.
module tb_alu_issue_sched;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  alu_issue_sched_if #(.LAT_W(3)) bus ();

  alu_issue_sched #(.LAT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: each ALU is free from cycle free_at onward.
  int         cyc;
  int         free_at [2];
  bit         m_rr;
  bit         e_start [2];
  bit         e_src   [2];
  logic [2:0] e_lat   [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    free_at[0] = 0; free_at[1] = 0;
    m_rr = 1'b0;
    for (int n = 0; n < 2; n++) begin
      e_start[n] = 1'b0; e_src[n] = 1'b0; e_lat[n] = 3'd0;
    end
  endtask

  // One cycle: drive at negedge, check outputs, advance model at posedge.
  task automatic step(input bit v1, input logic [2:0] l1, input bit v2,
                      input logic [2:0] l2, input bit fl,
                      output bit got1, output bit got2);
    bit         fr [2];
    bit         g  [2];
    bit         gs [2];
    logic [2:0] gl [2];
    int         nfree;
    int         n;
    @(negedge clk);
    bus.dp_valid1 = v1; bus.dp_lat1 = l1;
    bus.dp_valid2 = v2; bus.dp_lat2 = l2;
    bus.flush     = fl;
    #1;
    fr[0] = (cyc >= free_at[0]);
    fr[1] = (cyc >= free_at[1]);
    nfree = int'(fr[0]) + int'(fr[1]);
    check("fu_busy", 32'({!fr[1], !fr[0]}), 32'(bus.fu_busy));
    check("rr_ptr",    32'(bus.rr_ptr),    32'(m_rr));
    check("fu0_start", 32'(bus.fu0_start), 32'(e_start[0]));
    check("fu0_src",   32'(bus.fu0_src),   32'(e_src[0]));
    check("fu0_lat",   32'(bus.fu0_lat),   32'(e_lat[0]));
    check("fu1_start", 32'(bus.fu1_start), 32'(e_start[1]));
    check("fu1_src",   32'(bus.fu1_src),   32'(e_src[1]));
    check("fu1_lat",   32'(bus.fu1_lat),   32'(e_lat[1]));
    g[0] = 0; g[1] = 0; gs[0] = 0; gs[1] = 0; gl[0] = 0; gl[1] = 0;
    got1 = 0; got2 = 0;
    if (!fl && nfree > 0) begin
      if (v1 && v2) begin
        if (nfree == 2) begin
          g[0] = 1; gl[0] = l1;
          g[1] = 1; gl[1] = l2; gs[1] = 1;
          got1 = 1; got2 = 1;
        end else begin
          n = fr[0] ? 0 : 1;
          g[n] = 1; gl[n] = l1; got1 = 1;
        end
      end else if (v1 || v2) begin
        n = (nfree == 2) ? int'(m_rr) : (fr[0] ? 0 : 1);
        g[n] = 1; gl[n] = v1 ? l1 : l2; gs[n] = !v1;
        got1 = v1; got2 = v2;
      end
    end
    check("dp_ready1", 32'(bus.dp_ready1), 32'(got1));
    check("dp_ready2", 32'(bus.dp_ready2), 32'(got2));
    @(posedge clk);
    if (fl) begin
      free_at[0] = 0; free_at[1] = 0;
      m_rr = 1'b0;
      e_start[0] = 0; e_start[1] = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        e_start[k] = g[k];
        if (g[k]) begin
          e_src[k]   = gs[k];
          e_lat[k]   = gl[k];
          free_at[k] = cyc + ((gl[k] == 3'd0) ? 1 : int'(gl[k]));
        end
      end
      if (g[0] != g[1]) m_rr = g[0];
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.dp_valid1 = 0; bus.dp_valid2 = 0; bus.flush = 0;
    bus.dp_lat1 = 0; bus.dp_lat2 = 0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  bit         r1, r2;
  bit         p1, p2, fl;
  logic [2:0] pl1, pl2;

  initial begin
    rst = 1'b1;
    bus.flush = 0; bus.dp_valid1 = 0; bus.dp_valid2 = 0;
    bus.dp_lat1 = 0; bus.dp_lat2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    bus.dp_valid1 = 1; bus.dp_valid2 = 1;
    #1;
    check("rst_ready1", 32'(bus.dp_ready1), 32'd0);
    check("rst_ready2", 32'(bus.dp_ready2), 32'd0);
    check("rst_busy",   32'(bus.fu_busy),   32'd0);
    check("rst_start",  32'({bus.fu1_start, bus.fu0_start}), 32'd0);
    do_reset();

    // Dual grant, then single-slot alternation.
    step(1, 3'd1, 1, 3'd1, 0, r1, r2);
    check("dual_grant", 32'({r2, r1}), 32'd3);
    for (int i = 0; i < 5; i++) step(1, 3'd1, 0, 3'd0, 0, r1, r2);

    // Busy blocking with latency 4 on both ALUs.
    step(1, 3'd4, 1, 3'd4, 0, r1, r2);
    for (int i = 0; i < 5; i++) step(1, 3'd2, 1, 3'd2, 0, r1, r2);

    // Partial availability: ALU0 busy, both slots valid.
    do_reset();
    step(1, 3'd5, 0, 3'd0, 0, r1, r2);
    step(1, 3'd3, 1, 3'd6, 0, r1, r2);
    check("partial_only_slot1", 32'({r2, r1}), 32'd1);
    step(0, 3'd0, 0, 3'd0, 0, r1, r2);

    // Flush two cycles after a latency-7 grant, then an immediate new grant.
    do_reset();
    step(1, 3'd7, 0, 3'd0, 0, r1, r2);
    step(0, 3'd0, 0, 3'd0, 0, r1, r2);
    step(1, 3'd2, 1, 3'd2, 1, r1, r2);
    step(1, 3'd2, 0, 3'd0, 0, r1, r2);
    check("post_flush_grant", 32'(r1), 32'd1);
    step(0, 3'd0, 0, 3'd0, 0, r1, r2);

    // Latency 0 behaves as 1: ALU free again the next cycle.
    step(1, 3'd0, 1, 3'd0, 0, r1, r2);
    step(1, 3'd0, 1, 3'd0, 0, r1, r2);

    // Asynchronous reset between edges while fu1_start is high.
    do_reset();
    step(1, 3'd3, 1, 3'd3, 0, r1, r2);
    #1;
    check("pre_rst_fu1_start", 32'(bus.fu1_start), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_fu1_start", 32'(bus.fu1_start), 32'd0);
    check("async_fu0_start", 32'(bus.fu0_start), 32'd0);
    check("async_fu_busy",   32'(bus.fu_busy),   32'd0);
    check("async_rr_ptr",    32'(bus.rr_ptr),    32'd0);
    check("async_ready1",    32'(bus.dp_ready1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bus.dp_valid1 = 0; bus.dp_valid2 = 0;
    step(0, 3'd0, 0, 3'd0, 0, r1, r2);

    // Random traffic: each slot holds its request until granted.
    p1 = 0; p2 = 0; pl1 = 0; pl2 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!p1 && ($urandom_range(9) < 6)) begin p1 = 1; pl1 = 3'($urandom_range(7)); end
      if (!p2 && ($urandom_range(9) < 5)) begin p2 = 1; pl2 = 3'($urandom_range(7)); end
      fl = ($urandom_range(39) == 0);
      step(p1, pl1, p2, pl2, fl, r1, r2);
      if (fl) begin
        p1 = 0; p2 = 0;
      end else begin
        if (r1) p1 = 0;
        if (r2) p2 = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
